// File: rtl/byte_stream_pkg.sv
// Shared types and defaults for the ByteStreamer sequencer slice.
package byte_stream_pkg;
  localparam int unsigned BYTE_W_DEFAULT    = 8;
  localparam int unsigned FRAME_LEN_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/byte_stream_ctrl_if.sv
// Downstream byte valid/ready channel; master drives data and valid.
interface byte_stream_ctrl_if
  import byte_stream_pkg::*;
#(
  parameter int unsigned BYTE_W = BYTE_W_DEFAULT
);
  logic [BYTE_W-1:0] byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_data, output byte_valid, input byte_ready);
  modport slave  (input byte_data, input byte_valid, output byte_ready);
endinterface

// File: rtl/byte_hold_reg.sv
// One-deep holding register between the streamer and the byte consumer,
// with sticky overrun when a completed byte finds the slot still occupied.
module byte_hold_reg #(
  parameter int unsigned BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_capture,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_ready,
  input  logic              i_clr_overrun,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_overrun,
  output logic              o_accept
);
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic              r_overrun;
  logic              w_load;
  logic              w_drop;

  assign o_accept = r_valid && i_ready;
  // The slot frees on the same edge it is accepted, so accept+capture reloads.
  assign w_load   = i_capture && (!r_valid || i_ready);
  assign w_drop   = i_capture && r_valid && !i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (o_accept) begin
        r_valid <= 1'b0;
      end
      if (w_drop)
        r_overrun <= 1'b1;
      else if (i_clr_overrun)
        r_overrun <= 1'b0;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
endmodule

// File: rtl/byte_stream_ctrl.sv
// ByteStreamer sequencer: gates serial bits into the streamer, counts bits
// and bytes per frame, and hands completed bytes to the holding register.
module byte_stream_ctrl
  import byte_stream_pkg::*;
#(
  parameter int unsigned BYTE_W    = BYTE_W_DEFAULT,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_frame_start,
  input  logic                 i_bit_valid,
  input  logic                 i_bit_in,
  output logic                 o_shift_enable,
  output logic                 o_serial_out,
  input  logic [BYTE_W-1:0]    i_parallel_in,
  byte_stream_ctrl_if.master   bs,
  output logic                 o_frame_done,
  output logic                 o_busy,
  output logic [CNT_W-1:0]     o_byte_cnt,
  output logic                 o_overrun,
  input  logic                 i_clr_overrun
);
  localparam int unsigned      BIT_W    = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BYTE_W - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] r_byte_cnt;
  logic             r_capture_pend;
  logic             r_frame_done;
  logic             w_shift;
  logic             w_byte_end;
  logic             w_accept;
  logic             w_frame_end;

  assign w_shift     = i_bit_valid && (r_state == SHIFT);
  assign w_byte_end  = w_shift && (r_bit_cnt == BIT_LAST);
  // Frame ends only once no byte is still waiting to be captured.
  assign w_frame_end = (r_state == DRAIN) && w_accept && !r_capture_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_bit_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_capture_pend <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_capture_pend <= w_byte_end;
      r_frame_done   <= w_frame_end;
      case (r_state)
        IDLE: begin
          if (i_frame_start) begin
            r_state    <= SHIFT;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end
        end
        SHIFT: begin
          if (w_byte_end) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            if (r_byte_cnt == CNT_LAST)
              r_state <= DRAIN;
          end else if (w_shift) begin
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          end
        end
        DRAIN: begin
          if (w_frame_end)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  byte_hold_reg #(.BYTE_W(BYTE_W)) u_hold (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_capture     (r_capture_pend),
    .i_data        (i_parallel_in),
    .i_ready       (bs.byte_ready),
    .i_clr_overrun (i_clr_overrun),
    .o_data        (bs.byte_data),
    .o_valid       (bs.byte_valid),
    .o_overrun     (o_overrun),
    .o_accept      (w_accept)
  );

  assign o_shift_enable = w_shift;
  assign o_serial_out   = i_bit_in;
  assign o_frame_done   = r_frame_done;
  assign o_busy         = (r_state != IDLE);
  assign o_byte_cnt     = r_byte_cnt;
endmodule

// File: tb/tb_byte_stream_ctrl.sv
// Bench for byte_stream_ctrl with a behavioural ByteStreamer and a frame-level reference model.
module tb_byte_stream_ctrl;
  localparam int unsigned FL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Main DUT, FRAME_LEN=4
  logic       frame_start = 1'b0, bit_valid = 1'b0, bit_in = 1'b0, ready = 1'b0, clr_overrun = 1'b0;
  logic       shift_enable, serial_out, frame_done, busy, overrun;
  logic [2:0] byte_cnt;
  logic [7:0] sr;
  byte_stream_ctrl_if #(.BYTE_W(8)) bs ();
  assign bs.byte_ready = ready;

  byte_stream_ctrl #(.BYTE_W(8), .FRAME_LEN(FL)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_frame_start(frame_start), .i_bit_valid(bit_valid),
    .i_bit_in(bit_in), .o_shift_enable(shift_enable), .o_serial_out(serial_out),
    .i_parallel_in(sr), .bs(bs), .o_frame_done(frame_done), .o_busy(busy),
    .o_byte_cnt(byte_cnt), .o_overrun(overrun), .i_clr_overrun(clr_overrun)
  );

  // Second DUT, FRAME_LEN=1
  logic       f1_fs = 1'b0, f1_bv = 1'b0, f1_bi = 1'b0, f1_rdy = 1'b0, f1_clr = 1'b0;
  logic       f1_se, f1_so, f1_done, f1_busy, f1_ovr;
  logic [0:0] f1_cnt;
  logic [7:0] f1_sr;
  byte_stream_ctrl_if #(.BYTE_W(8)) f1_bs ();
  assign f1_bs.byte_ready = f1_rdy;

  byte_stream_ctrl #(.BYTE_W(8), .FRAME_LEN(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_frame_start(f1_fs), .i_bit_valid(f1_bv),
    .i_bit_in(f1_bi), .o_shift_enable(f1_se), .o_serial_out(f1_so),
    .i_parallel_in(f1_sr), .bs(f1_bs), .o_frame_done(f1_done), .o_busy(f1_busy),
    .o_byte_cnt(f1_cnt), .o_overrun(f1_ovr), .i_clr_overrun(f1_clr)
  );

  // ByteStreamer: shift-left, serial_in enters bit 0
  always @(posedge clk) if (shift_enable) sr <= {sr[6:0], serial_out};
  always @(posedge clk) if (f1_se) f1_sr <= {f1_sr[6:0], f1_so};

  // Reference model: frame phase 0=idle 1=collecting 2=draining
  int         m_phase, m_bits, m_bytes;
  int         m_acc = 0;
  bit         m_pend, m_valid, m_ovr, m_done;
  logic [7:0] m_pend_byte, m_data;
  bit         mx_acc, mx_fin, mx_pn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_bits = 0; m_bytes = 0; m_pend = 0;
      m_valid = 0; m_data = 8'h00; m_ovr = 0; m_done = 0;
    end else begin
      mx_acc = m_valid && ready;
      mx_fin = (m_phase == 2) && mx_acc && !m_pend;
      if (clr_overrun) m_ovr = 0;
      if (m_pend) begin
        if (!m_valid || ready) begin m_data = m_pend_byte; m_valid = 1; end
        else m_ovr = 1;
      end else if (mx_acc) m_valid = 0;
      mx_pn = 0;
      if (m_phase == 0 && frame_start) begin
        m_phase = 1; m_bits = 0; m_bytes = 0;
      end else if (m_phase == 1 && bit_valid) begin
        m_acc = ((m_acc << 1) | int'(bit_in)) % 256;
        m_bits++;
        if (m_bits == 8) begin
          m_bits = 0; m_bytes++; mx_pn = 1; m_pend_byte = 8'(m_acc);
          if (m_bytes == FL) m_phase = 2;
        end
      end else if (m_phase == 2 && mx_fin) m_phase = 0;
      m_pend = mx_pn;
      m_done = mx_fin;
    end
  end

  // Acceptance monitor: samples inputs as they will be seen at the next rising edge
  logic [7:0] mon_q[$];
  int         mon_done = 0;
  always @(negedge clk) begin
    #2;
    if (rst_n && bs.byte_valid && ready) mon_q.push_back(bs.byte_data);
    if (frame_done) mon_done++;
  end

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic set_in(input logic fs, input logic bv, input logic bi, input logic rdy, input logic clr);
    frame_start = fs; bit_valid = bv; bit_in = bi; ready = rdy; clr_overrun = clr;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 7; i >= 0; i--) begin
      set_in(1'b0, 1'b1, b[i], rdy, 1'b0);
      next_cyc();
    end
    set_in(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin next_cyc(); n++; end
    n_cmp++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL %s_idle_timeout: busy=%b want 0", tag, busy); end
    next_cyc(); next_cyc();
  endtask

  task automatic test_reset();
    bit_valid = 1'b1; f1_bv = 1'b1;
    #1;
    n_cmp++; if (shift_enable !== 1'b0) begin n_err++; $display("FAIL reset_shift_en: got %b want 0", shift_enable); end
    n_cmp++; if (bs.byte_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bs.byte_valid); end
    n_cmp++; if (bs.byte_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bs.byte_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (byte_cnt !== 3'd0) begin n_err++; $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    n_cmp++; if (f1_bs.byte_valid !== 1'b0 || f1_busy !== 1'b0) begin n_err++; $display("FAIL reset_f1: valid=%b busy=%b want 0 0", f1_bs.byte_valid, f1_busy); end
    next_cyc();
    bit_valid = 1'b0; f1_bv = 1'b0;
    rst_n = 1'b1;
    next_cyc();
  endtask

  task automatic test_frame_len1();
    logic [7:0] pat;
    pat = 8'b10100110;
    f1_rdy = 1'b1; f1_fs = 1'b1;
    next_cyc();
    f1_fs = 1'b0;
    for (int i = 7; i >= 0; i--) begin f1_bv = 1'b1; f1_bi = pat[i]; next_cyc(); end
    f1_bv = 1'b0;
    n_cmp++; if (f1_bs.byte_valid !== 1'b0) begin n_err++; $display("FAIL f1_valid_early: got %b want 0", f1_bs.byte_valid); end
    n_cmp++; if (f1_cnt !== 1'b1) begin n_err++; $display("FAIL f1_byte_cnt: got %0d want 1", f1_cnt); end
    next_cyc();
    n_cmp++; if (f1_bs.byte_valid !== 1'b1) begin n_err++; $display("FAIL f1_valid: got %b want 1", f1_bs.byte_valid); end
    n_cmp++; if (f1_bs.byte_data !== pat) begin n_err++; $display("FAIL f1_data: got %h want %h", f1_bs.byte_data, pat); end
    next_cyc();
    n_cmp++; if (f1_done !== 1'b1) begin n_err++; $display("FAIL f1_frame_done: got %b want 1", f1_done); end
    n_cmp++; if (f1_busy !== 1'b0 || f1_bs.byte_valid !== 1'b0) begin n_err++; $display("FAIL f1_end: busy=%b valid=%b want 0 0", f1_busy, f1_bs.byte_valid); end
    next_cyc();
    n_cmp++; if (f1_done !== 1'b0) begin n_err++; $display("FAIL f1_done_pulse: got %b want 0", f1_done); end
  endtask

  task automatic test_gapped();
    logic [7:0] exp[$] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
    logic [7:0] b;
    mon_q.delete(); mon_done = 0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); next_cyc();
    for (int k = 0; k < 4; k++) begin
      b = exp[k];
      for (int i = 7; i >= 0; i--) begin
        set_in(1'b0, 1'b1, b[i], 1'b1, 1'b0); #1;
        n_cmp++; if (shift_enable !== 1'b1 || serial_out !== b[i]) begin n_err++; $display("FAIL gap_shift_en: se=%b so=%b want 1 %b", shift_enable, serial_out, b[i]); end
        next_cyc();
        if (i == 0) begin
          n_cmp++; if (byte_cnt !== 3'(k + 1)) begin n_err++; $display("FAIL gap_byte_cnt: got %0d want %0d", byte_cnt, k + 1); end
        end
        for (int g = 0; g < 2; g++) begin
          set_in(1'b0, 1'b0, 1'($urandom), 1'b1, 1'b0); #1;
          n_cmp++; if (shift_enable !== 1'b0) begin n_err++; $display("FAIL gap_shift_idle: got %b want 0", shift_enable); end
          next_cyc();
        end
      end
    end
    wait_idle("gap");
    n_cmp++; if (mon_q.size() != 4) begin n_err++; $display("FAIL gap_count: got %0d want 4", mon_q.size()); end
    for (int k = 0; k < 4 && k < mon_q.size(); k++) begin
      n_cmp++; if (mon_q[k] !== exp[k]) begin n_err++; $display("FAIL gap_byte%0d: got %h want %h", k, mon_q[k], exp[k]); end
    end
    n_cmp++; if (mon_done != 1) begin n_err++; $display("FAIL gap_frame_done: got %0d want 1", mon_done); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b2;
    b2 = 8'h33;
    mon_q.delete(); mon_done = 0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); next_cyc();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    for (int i = 7; i >= 5; i--) begin set_in(1'b0, 1'b1, b2[i], 1'b0, 1'b0); next_cyc(); end
    n_cmp++; if (bs.byte_valid !== 1'b1 || bs.byte_data !== 8'h11) begin n_err++; $display("FAIL bp_hold: valid=%b data=%h want 1 11", bs.byte_valid, bs.byte_data); end
    n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL bp_overrun: got %b want 1", overrun); end
    n_cmp++; if (byte_cnt !== 3'd2) begin n_err++; $display("FAIL bp_byte_cnt: got %0d want 2", byte_cnt); end
    for (int i = 4; i >= 0; i--) begin set_in(1'b0, 1'b1, b2[i], 1'b0, 1'b0); next_cyc(); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) next_cyc();
    n_cmp++; if (overrun !== 1'b1 || bs.byte_data !== 8'h11) begin n_err++; $display("FAIL bp_sticky: ovr=%b data=%h want 1 11", overrun, bs.byte_data); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1); next_cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL bp_clear: got %b want 0", overrun); end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); next_cyc();
    send_byte(8'h44, 1'b1);
    wait_idle("bp");
    n_cmp++; if (mon_q.size() != 2 || mon_q[0] !== 8'h11 || mon_q[1] !== 8'h44) begin
      n_err++; $display("FAIL bp_delivered: got %0d bytes %p want 11 44", mon_q.size(), mon_q); end
  endtask

  task automatic test_same_edge();
    mon_q.delete(); mon_done = 0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); next_cyc();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    n_cmp++; if (bs.byte_valid !== 1'b1 || bs.byte_data !== 8'hA5) begin n_err++; $display("FAIL se_first: valid=%b data=%h want 1 a5", bs.byte_valid, bs.byte_data); end
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0); next_cyc();
    n_cmp++; if (bs.byte_valid !== 1'b1 || bs.byte_data !== 8'h3C) begin n_err++; $display("FAIL se_switch: valid=%b data=%h want 1 3c", bs.byte_valid, bs.byte_data); end
    n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL se_overrun: got %b want 0", overrun); end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0); next_cyc();
    n_cmp++; if (bs.byte_valid !== 1'b1 || bs.byte_data !== 8'h3C) begin n_err++; $display("FAIL se_stall: valid=%b data=%h want 1 3c", bs.byte_valid, bs.byte_data); end
    send_byte(8'h5A, 1'b1);
    send_byte(8'h0F, 1'b1);
    wait_idle("se");
    n_cmp++; if (mon_q.size() != 4 || mon_q[0] !== 8'hA5 || mon_q[1] !== 8'h3C || mon_q[2] !== 8'h5A || mon_q[3] !== 8'h0F) begin
      n_err++; $display("FAIL se_delivered: got %p want a5 3c 5a 0f", mon_q); end
    n_cmp++; if (mon_done != 1) begin n_err++; $display("FAIL se_frame_done: got %0d want 1", mon_done); end
  endtask

  task automatic test_reset_mid_byte();
    mon_q.delete(); mon_done = 0;
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); next_cyc();
    for (int i = 0; i < 5; i++) begin set_in(1'b0, 1'b1, 1'($urandom), 1'b1, 1'b0); next_cyc(); end
    rst_n = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0 || byte_cnt !== 3'd0 || shift_enable !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_ctrl: busy=%b cnt=%0d se=%b want 0 0 0", busy, byte_cnt, shift_enable); end
    n_cmp++; if (bs.byte_valid !== 1'b0 || bs.byte_data !== 8'h00 || overrun !== 1'b0 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_out: valid=%b data=%h ovr=%b done=%b want 0 00 0 0", bs.byte_valid, bs.byte_data, overrun, frame_done); end
    next_cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    next_cyc();
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); next_cyc();
    send_byte(8'h81, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1);
    wait_idle("rst");
    n_cmp++; if (mon_q.size() != 4 || mon_q[0] !== 8'h81 || mon_q[3] !== 8'h03) begin
      n_err++; $display("FAIL rst_new_frame: got %p want 81 01 02 03", mon_q); end
  endtask

  task automatic test_ignored();
    logic [7:0] b;
    b = 8'hC3;
    mon_q.delete(); mon_done = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0); #1;
      n_cmp++; if (shift_enable !== 1'b0) begin n_err++; $display("FAIL ign_idle_shift: got %b want 0", shift_enable); end
      next_cyc();
    end
    n_cmp++; if (byte_cnt !== 3'd4 || busy !== 1'b0) begin n_err++; $display("FAIL ign_idle_cnt: cnt=%0d busy=%b want 4 0", byte_cnt, busy); end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); next_cyc();
    for (int i = 7; i >= 5; i--) begin set_in(1'b0, 1'b1, b[i], 1'b1, 1'b0); next_cyc(); end
    set_in(1'b1, 1'b1, b[4], 1'b1, 1'b0); next_cyc();
    n_cmp++; if (busy !== 1'b1 || byte_cnt !== 3'd0) begin n_err++; $display("FAIL ign_restart: busy=%b cnt=%0d want 1 0", busy, byte_cnt); end
    for (int i = 3; i >= 0; i--) begin set_in(1'b0, 1'b1, b[i], 1'b1, 1'b0); next_cyc(); end
    send_byte(8'h96, 1'b1); send_byte(8'hE1, 1'b1); send_byte(8'h7E, 1'b1);
    wait_idle("ign");
    n_cmp++; if (mon_q.size() != 4 || mon_q[0] !== 8'hC3 || mon_q[1] !== 8'h96 || mon_q[2] !== 8'hE1 || mon_q[3] !== 8'h7E) begin
      n_err++; $display("FAIL ign_delivered: got %p want c3 96 e1 7e", mon_q); end
    n_cmp++; if (mon_done != 1) begin n_err++; $display("FAIL ign_frame_done: got %0d want 1", mon_done); end
  endtask

  task automatic test_random();
    logic fs, bv;
    for (int c = 0; c < 800; c++) begin
      fs = (m_phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      bv = ($urandom_range(0, 2) != 0);
      set_in(fs, bv, 1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      #1;
      n_cmp++; if (shift_enable !== ((m_phase == 1) && bv)) begin n_err++; $display("FAIL rnd_shift_en c%0d: got %b want %b", c, shift_enable, (m_phase == 1) && bv); end
      next_cyc();
      n_cmp++; if (bs.byte_valid !== m_valid || bs.byte_data !== m_data) begin
        n_err++; $display("FAIL rnd_out c%0d: valid=%b data=%h want %b %h", c, bs.byte_valid, bs.byte_data, m_valid, m_data); end
      n_cmp++; if (overrun !== m_ovr || frame_done !== m_done) begin
        n_err++; $display("FAIL rnd_flags c%0d: ovr=%b done=%b want %b %b", c, overrun, frame_done, m_ovr, m_done); end
      n_cmp++; if (busy !== (m_phase != 0) || byte_cnt !== 3'(m_bytes)) begin
        n_err++; $display("FAIL rnd_ctrl c%0d: busy=%b cnt=%0d want %b %0d", c, busy, byte_cnt, m_phase != 0, m_bytes); end
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    next_cyc();
    test_reset();
    test_frame_len1();
    test_gapped();
    test_backpressure();
    test_same_edge();
    test_reset_mid_byte();
    test_ignored();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/byte_stream_ctrl.md
Name: byte_stream_ctrl

Overview:
Sequencer for the ByteStreamer serial-to-parallel shift register. It gates qualified serial bits into the streamer (drives shift_enable / serial_in) and counts BYTE_W bits per byte and FRAME_LEN bytes per frame. It captures each completed byte from the streamer's parallel_out into a holding register and presents it on a valid/ready interface to the downstream byte consumer.

Parameters:
BYTE_W, 8, bits per byte; must equal the ByteStreamer width.
FRAME_LEN, 4, bytes per frame (>=1).
CNT_W, $clog2(FRAME_LEN+1), width of byte_cnt.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  single-cycle pulse; opens a frame (sampled only in IDLE)
bit_valid  in  1  bit_in qualifier, one bit per asserted cycle
bit_in  in  1  serial data bit
shift_enable  out  1  to ByteStreamer.shift_enable
serial_out  out  1  to ByteStreamer.serial_in
parallel_in  in  BYTE_W  from ByteStreamer.parallel_out
byte_data  out  BYTE_W  captured byte
byte_valid  out  1  byte_data valid; held until accepted
byte_ready  in  1  downstream accept
frame_done  out  1  one-cycle pulse when the last byte of the frame is accepted
busy  out  1  high when state != IDLE
byte_cnt  out  CNT_W  bytes fully shifted in the current frame
overrun  out  1  sticky; a completed byte was dropped
clr_overrun  in  1  synchronous clear of overrun

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bit_cnt=0, byte_cnt=0, capture_pend=0, byte_data=0, byte_valid=0, frame_done=0, overrun=0. shift_enable=0 while in reset.
- shift_enable is combinational: bit_valid && state==SHIFT. serial_out = bit_in, combinational. The streamer shifts on the same clk edge.
- States:
  - IDLE -> SHIFT on frame_start; clears bit_cnt and byte_cnt.
  - SHIFT: each qualified bit increments bit_cnt. On the BYTE_W-th bit: bit_cnt wraps to 0, byte_cnt increments, capture_pend is set. If byte_cnt reaches FRAME_LEN, go to DRAIN.
  - DRAIN -> IDLE when the last byte has been captured and accepted (byte_valid && byte_ready with no capture_pend); frame_done pulses on that same edge.
- Capture: capture_pend is set on the edge of the final shift, so parallel_in is valid in the following cycle. In that cycle:
  - byte_data <= parallel_in and byte_valid <= 1, if byte_valid==0 or byte_ready==1.
  - Otherwise the new byte is dropped, overrun <= 1, byte_data is retained, and the byte is still counted.
  - capture_pend clears in all cases.
- Handshake: acceptance = byte_valid && byte_ready. byte_valid falls after acceptance unless a capture occurs on the same edge, in which case it stays 1 with the new data. byte_data is stable while byte_valid && !byte_ready.
- Shifting continues during capture and stall; the holding register gives one byte of slack.
- bit_valid outside SHIFT: ignored, shift_enable=0, no count change. frame_start outside IDLE: ignored.
- overrun: clr_overrun clears it; a simultaneous set wins.
- Reset mid-frame: everything returns to reset values immediately. The streamer's contents are don't-care; the next frame starts bit_cnt from 0.
- Latency: last bit edge -> byte_valid high after 1 cycle.

Decomposition:
- Shared package byte_stream_pkg:
  - state enum {IDLE, SHIFT, DRAIN} (2-bit encoding)
  - BYTE_W_DEFAULT=8, FRAME_LEN_DEFAULT=4
- One natural sub-module: byte_hold_reg, the capture/valid-ready holding register with overrun detection.
- Counters and FSM stay in the top level.

Test Plan:
- Bench instantiates ByteStreamer (shift-left, serial_in enters bit 0) alongside the controller.
1. Single frame, FRAME_LEN=1: frame_start, then bits 1,0,1,0,0,1,1,0 on consecutive cycles with byte_ready=1 -> byte_valid high 1 cycle after the 8th bit with byte_data=8'b10100110; frame_done pulses; busy drops.
2. Gapped bits, FRAME_LEN=4: bit_valid asserted every 3rd cycle, bytes 8'hA5, 8'h3C, 8'hFF, 8'h00 -> shift_enable only on qualified cycles; four bytes delivered in order; byte_cnt steps 1..4; exactly one frame_done.
3. Backpressure: byte_ready=0 through byte 1 and into byte 2 of a frame -> byte_data holds byte 0, byte 1 is dropped, overrun=1 and stays set until a clr_overrun pulse.
4. Same-edge accept+capture: byte_ready asserted exactly on the capture cycle of byte 1 -> byte_valid stays 1, data switches 8'hA5->8'h3C, overrun remains 0.
5. Reset mid-byte: drop rst_n after 5 bits -> all outputs reach reset values immediately; a new frame with 8'h81 is captured correctly.
6. Ignored events: bit_valid in IDLE and frame_start in SHIFT -> no shift_enable in IDLE, counters unchanged, frame still completes normally.
